// File: rtl/fuzzy_mmio_regs.sv
// rtl/fuzzy_mmio_regs.sv - MMIO register file and single-evaluation sequencer for the fuzzy core
module fuzzy_mmio_regs #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              rd,
   input  logic              wr,
   input  logic [7:0]        addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              core_start,
   output logic [DATA_W-1:0] core_T,
   output logic [DATA_W-1:0] core_dT,
   output logic              core_reg_mode,
   output logic              core_dt_mode,
   input  logic              core_done,
   input  logic [DATA_W-1:0] core_G
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [7:0] A_STATUS = 8'h00;
   localparam logic [7:0] A_CTRL   = 8'h01;
   localparam logic [7:0] A_T      = 8'h02;
   localparam logic [7:0] A_DT     = 8'h03;
   localparam logic [7:0] A_G      = 8'h04;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   wait_cnt;
   logic [DATA_W-1:0]  t_reg;
   logic [DATA_W-1:0]  dt_reg;
   logic [DATA_W-1:0]  t_prev;
   logic [DATA_W-1:0]  g_reg;
   logic               valid;
   logic               err;
   logic               dt_mode;
   logic               reg_mode;

   logic               wr_en;
   logic               ctrl_wr;
   logic               do_init;
   logic               do_start;
   logic               busy;
   logic [DATA_W:0]    diff;
   logic [DATA_W-1:0]  dt_sat;

   assign wr_en    = cs & wr;
   assign ctrl_wr  = wr_en && (addr == A_CTRL);
   assign do_init  = ctrl_wr & wdata[3];
   assign do_start = ctrl_wr & wdata[0];
   assign busy     = (state != S_IDLE);

   // Sign-extend both operands by one bit so the difference never wraps, then clamp
   // to the DATA_W signed range when the top two bits disagree.
   assign diff   = {t_reg[DATA_W-1], t_reg} - {t_prev[DATA_W-1], t_prev};
   assign dt_sat = (diff[DATA_W] != diff[DATA_W-1])
                   ? {diff[DATA_W], {(DATA_W-1){~diff[DATA_W]}}}
                   : diff[DATA_W-1:0];

   // Registers, launch sequencer and timeout counter; INIT overrides everything else in the CTRL write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         wait_cnt      <= '0;
         t_reg         <= '0;
         dt_reg        <= '0;
         t_prev        <= '0;
         g_reg         <= '0;
         valid         <= 1'b0;
         err           <= 1'b0;
         dt_mode       <= 1'b0;
         reg_mode      <= 1'b0;
         core_start    <= 1'b0;
         core_T        <= '0;
         core_dT       <= '0;
         core_reg_mode <= 1'b0;
         core_dt_mode  <= 1'b0;
      end else begin
         core_start <= 1'b0;

         if (wr_en && (addr == A_T))
            t_reg <= wdata;
         if (wr_en && (addr == A_DT))
            dt_reg <= wdata;
         if (ctrl_wr) begin
            dt_mode  <= wdata[2];
            reg_mode <= wdata[1];
         end

         if (do_init) begin
            valid    <= 1'b0;
            err      <= 1'b0;
            g_reg    <= '0;
            t_prev   <= '0;
            wait_cnt <= '0;
            state    <= S_IDLE;
         end else begin
            if (do_start && busy)
               err <= 1'b1;

            case (state)
               S_IDLE: begin
                  if (do_start) begin
                     // Mode bits come from the same CTRL write that carries START.
                     valid         <= 1'b0;
                     core_T        <= t_reg;
                     core_reg_mode <= wdata[1];
                     core_dt_mode  <= wdata[2];
                     if (wdata[2]) begin
                        core_dT <= dt_sat;
                        dt_reg  <= dt_sat;
                        t_prev  <= t_reg;
                     end else begin
                        core_dT <= dt_reg;
                     end
                     core_start <= 1'b1;
                     state      <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  wait_cnt <= '0;
                  state    <= S_WAIT;
               end
               S_WAIT: begin
                  if (core_done) begin
                     g_reg <= core_G;
                     valid <= 1'b1;
                     state <= S_IDLE;
                  end else if (wait_cnt == CNT_LAST) begin
                     err   <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // Read mux; CTRL reads back only the mode bits, unmapped addresses read zero.
   always_comb begin
      rdata = '0;
      if (cs && rd) begin
         case (addr)
            A_STATUS: rdata[2:0] = {err, busy, valid};
            A_CTRL:   rdata[2:0] = {dt_mode, reg_mode, 1'b0};
            A_T:      rdata = t_reg;
            A_DT:     rdata = dt_reg;
            A_G:      rdata = g_reg;
            default:  rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_fuzzy_mmio_regs.sv
// tb/tb_fuzzy_mmio_regs.sv - table-driven bench for fuzzy_mmio_regs with a one-cycle core model
module tb_fuzzy_mmio_regs;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cs = 1'b0;
   logic       rd = 1'b0;
   logic       wr = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] wdata = 8'h00;
   logic [7:0] rdata;
   logic       core_start;
   logic [7:0] core_T;
   logic [7:0] core_dT;
   logic       core_reg_mode;
   logic       core_dt_mode;
   logic       core_done = 1'b0;
   logic [7:0] core_G = 8'h00;

   int         n_vec = 0;
   int         n_bad = 0;
   int         pulses = 0;
   logic       respond = 1'b1;
   logic [7:0] g_resp = 8'h55;
   logic       pend = 1'b0;

   fuzzy_mmio_regs #(.DATA_W(8), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .core_start(core_start), .core_T(core_T), .core_dT(core_dT),
      .core_reg_mode(core_reg_mode), .core_dt_mode(core_dt_mode),
      .core_done(core_done), .core_G(core_G)
   );

   always #10 clk = ~clk;

   // Core model: core_done one cycle after core_start, driven on the falling edge.
   always @(negedge clk) begin
      core_done = pend;
      core_G    = g_resp;
      pend      = core_start & respond;
      if (core_start) pulses++;
   end

   typedef enum int {OP_WR, OP_RD, OP_TICK, OP_CT, OP_CDT, OP_CS} op_t;
   typedef struct {
      op_t        op;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] exp;
      string      name;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input op_t op, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp, input string name);
      vec_t v;
      v.op = op; v.a = a; v.d = d; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h want %02h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
      cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
      @(posedge clk);
      #1;
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic bus_rd(input logic [7:0] a, output logic [7:0] v);
      cs = 1'b1; rd = 1'b1; addr = a;
      #1;
      v = rdata;
      cs = 1'b0; rd = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string name);
      logic [7:0] v;
      bus_rd(a, v);
      check(name, v, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;

      // Reset, unmapped/RO writes ignored
      add(OP_RD, 8'h00, 8'h00, 8'h00, "rst_status");
      add(OP_RD, 8'h01, 8'h00, 8'h00, "rst_ctrl");
      add(OP_RD, 8'h02, 8'h00, 8'h00, "rst_t");
      add(OP_RD, 8'h03, 8'h00, 8'h00, "rst_dt");
      add(OP_RD, 8'h04, 8'h00, 8'h00, "rst_g");
      add(OP_RD, 8'h05, 8'h00, 8'h00, "rst_unmapped");
      add(OP_CT, 8'h00, 8'h00, 8'h00, "rst_core_t");
      add(OP_CDT, 8'h00, 8'h00, 8'h00, "rst_core_dt");
      add(OP_CS, 8'h00, 8'h00, 8'h00, "rst_core_start");
      add(OP_WR, 8'h00, 8'hFF, 8'h00, "");
      add(OP_WR, 8'h04, 8'hAA, 8'h00, "");
      add(OP_WR, 8'h05, 8'h77, 8'h00, "");
      add(OP_RD, 8'h00, 8'h00, 8'h00, "ro_status");
      add(OP_RD, 8'h04, 8'h00, 8'h00, "ro_g");
      add(OP_RD, 8'h05, 8'h00, 8'h00, "unmapped");
      // DT_MODE=0 evaluation
      add(OP_WR, 8'h02, 8'h20, 8'h00, "");
      add(OP_WR, 8'h03, 8'hF0, 8'h00, "");
      add(OP_RD, 8'h02, 8'h00, 8'h20, "t_rw");
      add(OP_RD, 8'h03, 8'h00, 8'hF0, "dt_rw");
      add(OP_WR, 8'h01, 8'h01, 8'h00, "");
      add(OP_CS, 8'h00, 8'h00, 8'h01, "dt0_core_start");
      add(OP_CT, 8'h00, 8'h00, 8'h20, "dt0_core_t");
      add(OP_CDT, 8'h00, 8'h00, 8'hF0, "dt0_core_dt");
      add(OP_RD, 8'h00, 8'h00, 8'h02, "dt0_busy_a");
      add(OP_TICK, 8'h00, 8'h00, 8'h00, "");
      add(OP_CS, 8'h00, 8'h00, 8'h00, "dt0_start_one_cycle");
      add(OP_RD, 8'h00, 8'h00, 8'h02, "dt0_poll1");
      add(OP_TICK, 8'h00, 8'h00, 8'h00, "");
      add(OP_RD, 8'h00, 8'h00, 8'h01, "dt0_poll2");
      add(OP_RD, 8'h04, 8'h00, 8'h55, "dt0_g");
      add(OP_RD, 8'h00, 8'h00, 8'h01, "valid_sticky");
      add(OP_RD, 8'h01, 8'h00, 8'h00, "ctrl_rb0");
      // DT_MODE=1 evaluations
      add(OP_WR, 8'h02, 8'h10, 8'h00, "");
      add(OP_WR, 8'h01, 8'h05, 8'h00, "");
      add(OP_CT, 8'h00, 8'h00, 8'h10, "dt1a_core_t");
      add(OP_CDT, 8'h00, 8'h00, 8'h10, "dt1a_core_dt");
      add(OP_RD, 8'h00, 8'h00, 8'h02, "dt1a_valid_cleared");
      add(OP_TICK, 8'h00, 8'h00, 8'h00, "");
      add(OP_TICK, 8'h00, 8'h00, 8'h00, "");
      add(OP_WR, 8'h02, 8'h30, 8'h00, "");
      add(OP_WR, 8'h01, 8'h05, 8'h00, "");
      add(OP_CDT, 8'h00, 8'h00, 8'h20, "dt1b_core_dt");
      add(OP_TICK, 8'h00, 8'h00, 8'h00, "");
      add(OP_TICK, 8'h00, 8'h00, 8'h00, "");
      add(OP_RD, 8'h03, 8'h00, 8'h20, "dt1b_readback");
      add(OP_RD, 8'h01, 8'h00, 8'h04, "ctrl_rb_dtmode");
      // Saturation across INIT
      add(OP_WR, 8'h02, 8'h7F, 8'h00, "");
      add(OP_WR, 8'h01, 8'h05, 8'h00, "");
      add(OP_CDT, 8'h00, 8'h00, 8'h4F, "sat_pre_dt");
      add(OP_TICK, 8'h00, 8'h00, 8'h00, "");
      add(OP_TICK, 8'h00, 8'h00, 8'h00, "");
      add(OP_WR, 8'h01, 8'h0C, 8'h00, "");
      add(OP_RD, 8'h00, 8'h00, 8'h00, "init_status");
      add(OP_RD, 8'h04, 8'h00, 8'h00, "init_g");
      add(OP_WR, 8'h02, 8'h80, 8'h00, "");
      add(OP_WR, 8'h01, 8'h05, 8'h00, "");
      add(OP_CDT, 8'h00, 8'h00, 8'h80, "sat_neg_dt");
      add(OP_TICK, 8'h00, 8'h00, 8'h00, "");
      add(OP_TICK, 8'h00, 8'h00, 8'h00, "");
      add(OP_WR, 8'h02, 8'h7F, 8'h00, "");
      add(OP_WR, 8'h01, 8'h05, 8'h00, "");
      add(OP_CDT, 8'h00, 8'h00, 8'h7F, "sat_pos_dt");
      add(OP_TICK, 8'h00, 8'h00, 8'h00, "");
      add(OP_TICK, 8'h00, 8'h00, 8'h00, "");
      add(OP_RD, 8'h03, 8'h00, 8'h7F, "sat_readback");
      add(OP_RD, 8'h00, 8'h00, 8'h01, "sat_status");

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (vecs[i]) begin
         logic [7:0] v;
         case (vecs[i].op)
            OP_WR:   bus_wr(vecs[i].a, vecs[i].d);
            OP_RD:   begin bus_rd(vecs[i].a, v); check(vecs[i].name, v, vecs[i].exp); end
            OP_TICK: tick();
            OP_CT:   check(vecs[i].name, core_T, vecs[i].exp);
            OP_CDT:  check(vecs[i].name, core_dT, vecs[i].exp);
            OP_CS:   check(vecs[i].name, {7'd0, core_start}, vecs[i].exp);
            default: ;
         endcase
      end

      // Timeout: the core never answers
      respond = 1'b0;
      bus_wr(8'h01, 8'h01);
      rd_chk(8'h00, 8'h02, "to_busy_a");
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (k == 1 || k == 16) rd_chk(8'h00, 8'h02, $sformatf("to_busy_a%0d", k));
      end
      tick();
      rd_chk(8'h00, 8'h04, "to_err");
      bus_wr(8'h01, 8'h08);
      rd_chk(8'h00, 8'h00, "to_init");

      // Second START while busy sets ERR and launches nothing
      p0 = pulses;
      bus_wr(8'h01, 8'h01);
      bus_wr(8'h01, 8'h01);
      tick();
      rd_chk(8'h00, 8'h06, "restart_err");
      check("restart_pulses", 8'(pulses - p0), 8'd1);
      bus_wr(8'h01, 8'h08);
      rd_chk(8'h00, 8'h00, "restart_init");

      // INIT+START while VALID=1
      respond = 1'b1;
      g_resp  = 8'h66;
      bus_wr(8'h01, 8'h01);
      tick();
      tick();
      rd_chk(8'h00, 8'h01, "is_valid");
      p0 = pulses;
      bus_wr(8'h01, 8'h09);
      check("is_no_start", {7'd0, core_start}, 8'h00);
      rd_chk(8'h00, 8'h00, "is_status");
      tick();
      rd_chk(8'h00, 8'h00, "is_idle");
      check("is_pulses", 8'(pulses - p0), 8'd0);

      // INIT during ISSUE; the late core_done must be ignored
      g_resp = 8'h33;
      bus_wr(8'h01, 8'h01);
      bus_wr(8'h01, 8'h08);
      rd_chk(8'h00, 8'h00, "late_idle");
      tick();
      tick();
      rd_chk(8'h00, 8'h00, "late_status");
      rd_chk(8'h04, 8'h00, "late_g");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fuzzy_mmio_regs.md
# fuzzy_mmio_regs

Memory-mapped register file and evaluation sequencer in front of the fuzzy inference core. It decodes the single-cycle MMIO bus and holds the T/dT operands and mode bits. On START it launches one core evaluation, captures the result G and reports it through STATUS. It is the block the system bench drives directly; the core sits downstream on a start/done handshake.

## Interface
- `DATA_W`, 8: bus data width and operand/result width (signed two's complement operands).
- `TIMEOUT`, 16: max cycles in WAIT before the evaluation is aborted.
- `clk`  in  1: single clock, all logic rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `cs`  in  1: bus select.
- `rd`  in  1: read strobe (qualified by cs).
- `wr`  in  1: write strobe (qualified by cs).
- `addr`  in  8: register address.
- `wdata`  in  DATA_W: write data.
- `rdata`  out  DATA_W: read data, combinational from addr while cs&rd, else 0.
- `core_start`  out  1: one-cycle launch pulse to core.
- `core_T`, `core_dT`  out  DATA_W: operands, latched at START acceptance.
- `core_reg_mode`, `core_dt_mode`  out  1: mode bits, latched at START acceptance.
- `core_done`  in  1: core result strobe.
- `core_G`  in  DATA_W: core result, valid with core_done.

## Operation
- Map:
  - 0x00 STATUS (RO): [0] VALID, [1] BUSY, [2] ERR.
  - 0x01 CTRL: [3] INIT (W1P), [2] DT_MODE, [1] REG_MODE, [0] START (W1P). Readback returns only [2:1].
  - 0x02 T (RW).
  - 0x03 dT (RW). In DT_MODE, reads return the last computed dT.
  - 0x04 G (RO).
  - Other addresses read 0; writes to them are ignored. Writes to RO registers are ignored.
- Write accepted on the edge where cs&wr=1. A CTRL write always updates DT_MODE/REG_MODE.
- INIT: clears VALID, ERR, G and T_prev; FSM returns to IDLE and aborts any evaluation. INIT wins over START in the same write.
- START, accepted in IDLE:
  - clears VALID;
  - latches the operands:
    - core_T = T;
    - core_dT = the dT register when DT_MODE=0;
    - core_dT = sat8(T − T_prev) when DT_MODE=1. Computed as a 9-bit signed difference, saturated to [−128, 127], also written into the dT register. T_prev is then set to T.
  - FSM goes IDLE→ISSUE.
- START while not IDLE: ignored, ERR set (sticky until INIT or reset).
- FSM:
  - IDLE: BUSY=0.
  - ISSUE: core_start=1 for exactly one cycle, then WAIT.
  - WAIT: on core_done, G←core_G, VALID←1, go to IDLE. After TIMEOUT cycles without core_done, set ERR, go to IDLE, leave VALID at 0.
- core_done outside WAIT is ignored.
- VALID is sticky. It clears only on START acceptance, INIT or reset. Reading G does not clear it.
- Writes to T/dT during BUSY update the registers but do not affect the latched core operands.

## Timing
- Reset (rst=1 at an edge):
  - all registers 0; FSM IDLE;
  - rdata=0, core_start=0, core_T=core_dT=0, core modes 0.
- Read: rdata is valid in the same cycle cs&rd is high, reflecting state after the previous edge.
- Edge A accepts START. core_start is high in cycle A..A+1. State is WAIT from A+1.
- With a core that raises core_done at A+1, VALID=1 and G updated after edge A+2. BUSY reads 1 after A and after A+1.
- Bench latency (STATUS polls after the START write) is 2 polls.
- Timeout: ERR set and BUSY=0 at edge A+1+TIMEOUT, counting WAIT cycles from A+1.
- rst or INIT in ISSUE/WAIT: next cycle IDLE; a late core_done is ignored.

## Test plan
- Reset, then read 0x00..0x05 -> all 0. core_start never pulses.
- DT_MODE=0: T=0x20, dT=0xF0, START; core model returns G=0x55 one cycle after core_start -> core_T=0x20, core_dT=0xF0, STATUS goes 0x02 then 0x01 on the 2nd poll; G reads 0x55.
- DT_MODE=1: T=0x10 then START; T=0x30 then START -> core_dT=0x10 then 0x20. Readback of 0x03 is 0x20.
- Saturation: DT_MODE=1, T=0x7F (T_prev 0x7F) → INIT → T=0x80 START gives dT=0x80. Then T=0x7F with T_prev=0x80 -> dT=0x7F (saturated, not 0xFF).
- Core model never responds (TIMEOUT=16) -> BUSY clears 17 edges after START acceptance; STATUS=0x04. A second START while BUSY also sets ERR. INIT -> STATUS=0x00.
- CTRL write 0x09 (INIT+START) while VALID=1 -> VALID=0, no core_start pulse, FSM stays IDLE.
